// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter: one owner at a time, each owner holds the grant for a
// per-channel quantum of cycles; optional fixed-priority mode with preemption.
module wrr_arbiter #(
    parameter int N  = 4,
    parameter int QW = 8,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    input  logic [N*QW-1:0] quantum,
    input  logic            mode,
    output logic [N-1:0]    gnt,
    output logic [IW-1:0]   gnt_id,
    output logic            gnt_valid,
    output logic            expire
);

    typedef enum logic {IDLE, OWN} state_t;

    state_t          state, state_nx;
    logic [IW-1:0]   owner, owner_nx;
    logic [IW-1:0]   base, base_nx;
    logic [QW-1:0]   cnt, cnt_nx;
    logic            own_mode, own_mode_nx;
    logic [N-1:0]    gnt_nx;
    logic [IW-1:0]   gnt_id_nx;
    logic            expire_nx;
    logic            do_grant;
    logic [N-1:0]    cand;
    logic [N-1:0]    owner_bit;
    logic [N-1:0]    lower;
    logic [IW-1:0]   win;

    // A zero quantum field still yields a one-cycle slice.
    function automatic logic [QW-1:0] eff_q(input logic [N*QW-1:0] q, input logic [IW-1:0] i);
        logic [QW-1:0] v;
        v = q[int'(i)*QW +: QW];
        return (v == '0) ? QW'(1) : v;
    endfunction

    // fp=1: lowest set index; fp=0: first set index at or after start, wrapping.
    function automatic logic [IW-1:0] pick(input logic [N-1:0] c, input logic fp,
                                           input logic [IW-1:0] start);
        logic [IW-1:0] w;
        logic          found;
        int            idx;
        w     = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx = fp ? k : int'(start) + k;
            if (idx >= N) idx = idx - N;
            if (!found && c[idx]) begin
                w     = IW'(idx);
                found = 1'b1;
            end
        end
        return w;
    endfunction

    always_comb begin
        owner_bit = '0;
        lower     = '0;
        for (int k = 0; k < N; k++) begin
            owner_bit[k] = (k == int'(owner));
            lower[k]     = (k < int'(owner));
        end
    end

    always_comb begin
        state_nx    = state;
        owner_nx    = owner;
        base_nx     = base;
        cnt_nx      = cnt;
        own_mode_nx = own_mode;
        gnt_nx      = gnt;
        gnt_id_nx   = gnt_id;
        expire_nx   = 1'b0;
        do_grant    = 1'b0;
        cand        = '0;
        win         = '0;

        case (state)
            IDLE: begin
                if (|req) begin
                    do_grant = 1'b1;
                    cand     = req;
                end
            end
            OWN: begin
                if (!req[owner]) begin
                    // A drop wins over simultaneous exhaustion, so no expire here.
                    if (|req) begin
                        do_grant = 1'b1;
                        cand     = req;
                    end else begin
                        state_nx  = IDLE;
                        gnt_nx    = '0;
                        gnt_id_nx = '0;
                        cnt_nx    = '0;
                    end
                end else if (mode && own_mode && |(req & lower)) begin
                    do_grant = 1'b1;
                    cand     = req;
                end else if (cnt == QW'(1)) begin
                    expire_nx = 1'b1;
                    if (|(req & ~owner_bit)) begin
                        do_grant = 1'b1;
                        cand     = req & ~owner_bit;
                    end else begin
                        cnt_nx = eff_q(quantum, owner);
                    end
                end else begin
                    cnt_nx = cnt - QW'(1);
                end
            end
            default: state_nx = IDLE;
        endcase

        if (do_grant) begin
            win         = pick(cand, mode, base);
            state_nx    = OWN;
            owner_nx    = win;
            base_nx     = (int'(win) == N - 1) ? '0 : win + IW'(1);
            cnt_nx      = eff_q(quantum, win);
            own_mode_nx = mode;
            gnt_nx      = '0;
            gnt_nx[win] = 1'b1;
            gnt_id_nx   = win;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            owner     <= '0;
            base      <= '0;
            cnt       <= '0;
            own_mode  <= 1'b0;
            gnt       <= '0;
            gnt_id    <= '0;
            gnt_valid <= 1'b0;
            expire    <= 1'b0;
        end else begin
            state     <= state_nx;
            owner     <= owner_nx;
            base      <= base_nx;
            cnt       <= cnt_nx;
            own_mode  <= own_mode_nx;
            gnt       <= gnt_nx;
            gnt_id    <= gnt_id_nx;
            gnt_valid <= |gnt_nx;
            expire    <= expire_nx;
        end
    end

endmodule

// File: tb/tb_wrr_arbiter.sv
// Bench for wrr_arbiter: slice-accounting model checked every cycle, plus directed literals.
module tb_wrr_arbiter;
    localparam int N  = 4;
    localparam int QW = 8;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [N-1:0]    req = '0;
    logic [N*QW-1:0] quantum = '0;
    logic            mode = 1'b0;
    logic [N-1:0]    gnt;
    logic [IW-1:0]   gnt_id;
    logic            gnt_valid;
    logic            expire;

    wrr_arbiter #(.N(N), .QW(QW)) dut (
        .clk(clk), .rst(rst), .req(req), .quantum(quantum), .mode(mode),
        .gnt(gnt), .gnt_id(gnt_id), .gnt_valid(gnt_valid), .expire(expire)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: who owns, how many cycles of the slice are used, and who owned last.
    int   m_own  = -1;
    int   m_used = 0;
    int   m_len  = 1;
    int   m_last = -1;
    bit   m_omode = 1'b0;
    bit   m_exp  = 1'b0;
    int   m_w;
    bit   m_low;
    logic [N-1:0] m_oth;

    function automatic int q_of(input int i);
        int v;
        v = int'(quantum[i*QW +: QW]);
        return (v == 0) ? 1 : v;
    endfunction

    function automatic int pick_m(input logic [N-1:0] c, input bit fp);
        int idx;
        for (int k = 0; k < N; k++) begin
            idx = fp ? k : (m_last + 1 + k) % N;
            if (c[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic m_grant(input int w);
        m_own   = w;
        m_used  = 0;
        m_len   = q_of(w);
        m_last  = w;
        m_omode = mode;
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_own = -1; m_used = 0; m_len = 1; m_last = -1; m_omode = 1'b0; m_exp = 1'b0;
        end else begin
            m_exp = 1'b0;
            m_low = 1'b0;
            for (int j = 0; j < N; j++) if (j < m_own && req[j]) m_low = 1'b1;
            if (m_own < 0) begin
                m_w = pick_m(req, mode);
                if (m_w >= 0) m_grant(m_w);
            end else if (!req[m_own]) begin
                m_w = pick_m(req, mode);
                if (m_w >= 0) m_grant(m_w);
                else m_own = -1;
            end else if (mode && m_omode && m_low) begin
                m_grant(pick_m(req, 1'b1));
            end else begin
                m_used++;
                if (m_used >= m_len) begin
                    m_exp = 1'b1;
                    m_oth = req;
                    m_oth[m_own] = 1'b0;
                    m_w = pick_m(m_oth, mode);
                    if (m_w >= 0) m_grant(m_w);
                    else begin
                        m_used = 0;
                        m_len  = q_of(m_own);
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("gnt", 32'(gnt), (m_own < 0) ? 32'd0 : (32'd1 << m_own));
        chk("gnt_id", 32'(gnt_id), (m_own < 0) ? 32'd0 : 32'(m_own));
        chk("gnt_valid", 32'(gnt_valid), (m_own < 0) ? 32'd0 : 32'd1);
        chk("expire", 32'(expire), 32'(m_exp));
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_q(input int v);
        for (int i = 0; i < N; i++) quantum[i*QW +: QW] = v[QW-1:0];
    endtask

    task automatic rst_pulse();
        #2 rst = 1'b0;
        cyc(1);
        rst = 1'b1;
    endtask

    initial begin
        set_q(10);
        #1;
        chk("reset gnt", 32'(gnt), 32'd0);
        chk("reset gnt_valid", 32'(gnt_valid), 32'd0);
        chk("reset gnt_id", 32'(gnt_id), 32'd0);
        chk("reset expire", 32'(expire), 32'd0);
        cyc(2);
        rst = 1'b1;

        // two requesters, quantum 10
        req = 4'b0011;
        cyc(1);  chk("A first gnt", 32'(gnt), 32'h1);
        cyc(9);  chk("A held gnt", 32'(gnt), 32'h1);
        cyc(1);  chk("A rotate gnt", 32'(gnt), 32'h2);
                 chk("A rotate expire", 32'(expire), 32'h1);
        cyc(10); chk("A back gnt", 32'(gnt), 32'h1);
                 chk("A back expire", 32'(expire), 32'h1);
        cyc(39);
        req = '0; rst_pulse();

        // four requesters, quantum 4, wrap 3->0
        set_q(4); req = 4'b1111;
        cyc(13); chk("B gnt3", 32'(gnt), 32'h8);
        cyc(4);  chk("B wrap gnt", 32'(gnt), 32'h1);
                 chk("B wrap expire", 32'(expire), 32'h1);
        cyc(23);
        req = '0; rst_pulse();

        // lone requester renews its own slice
        set_q(5); req = 4'b0001;
        cyc(1);  chk("C gnt", 32'(gnt), 32'h1);
        cyc(5);  chk("C renew gnt", 32'(gnt), 32'h1);
                 chk("C renew expire", 32'(expire), 32'h1);
        cyc(1);  chk("C expire low", 32'(expire), 32'h0);
        cyc(13);
        req = '0; rst_pulse();

        // fixed priority preemption
        mode = 1'b1; set_q(20); req = 4'b0100;
        cyc(3);  chk("D gnt2", 32'(gnt), 32'h4);
        req = 4'b0101;
        cyc(1);  chk("D preempt gnt", 32'(gnt), 32'h1);
                 chk("D preempt expire", 32'(expire), 32'h0);
        req = 4'b0100;
        cyc(1);  chk("D return gnt", 32'(gnt), 32'h4);
        cyc(3);
        req = '0; mode = 1'b0; rst_pulse();

        // owner drop hands over without a gap
        set_q(10); req = 4'b0011;
        cyc(2);  chk("E gnt0", 32'(gnt), 32'h1);
        req = 4'b0010;
        cyc(1);  chk("E drop gnt", 32'(gnt), 32'h2);
                 chk("E drop valid", 32'(gnt_valid), 32'h1);
                 chk("E drop expire", 32'(expire), 32'h0);
        cyc(2);
        req = '0; rst_pulse();

        // zero quantum -> one-cycle slices
        set_q(0); req = 4'b0011;
        cyc(1);  chk("E0 gnt0", 32'(gnt), 32'h1);
        cyc(1);  chk("E0 gnt1", 32'(gnt), 32'h2);
                 chk("E0 expire1", 32'(expire), 32'h1);
        cyc(1);  chk("E0 gnt0 again", 32'(gnt), 32'h1);
                 chk("E0 expire2", 32'(expire), 32'h1);
        cyc(4);
        req = '0; rst_pulse();

        // asynchronous reset mid-grant
        set_q(10); req = 4'b0001;
        cyc(3);  chk("F gnt0", 32'(gnt), 32'h1);
        #2 rst = 1'b0;
        #1;
        chk("F async gnt", 32'(gnt), 32'h0);
        chk("F async valid", 32'(gnt_valid), 32'h0);
        req = 4'b0100;
        cyc(1);  rst = 1'b1;
        cyc(1);  chk("F post gnt", 32'(gnt), 32'h4);
        req = 4'b0001;
        cyc(2);  chk("F2 gnt0", 32'(gnt), 32'h1);
        #2 rst = 1'b0;
        #1;
        req = 4'b0101;
        cyc(1);  rst = 1'b1;
        cyc(1);  chk("F rr restart", 32'(gnt), 32'h1);
        cyc(3);
        req = '0;
        cyc(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
